// File: rtl/isr_arbiter.sv
// isr_arbiter: round-robin sharing of one integer square-root unit among NUM_REQ requesters,
// with a done watchdog and a one-cycle acknowledge carrying the root back to the winner.
module isr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [64*NUM_REQ-1:0]      req_value,
   output logic [NUM_REQ-1:0]         ack,
   output logic [31:0]                resp_result,
   output logic                       resp_timeout,
   output logic                       busy,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       isr_reset,
   output logic [63:0]                isr_value,
   input  logic [31:0]                isr_result,
   input  logic                       isr_done
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(TIMEOUT);
   typedef enum logic [2:0] {IDLE, LOAD, SETTLE, WAIT, RESP} state_t;
   state_t state, state_next;
   logic [IW-1:0] last_grant, last_grant_next, grant_next, pick, idx;
   logic found;
   logic [63:0] value_next;
   logic [31:0] result_next;
   logic timeout_next;
   logic [CW-1:0] watchdog, watchdog_next;
   // scan downward so the requester closest after last_grant wins
   always_comb begin
      pick = last_grant;
      found = 1'b0;
      idx = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         idx = IW'((int'(last_grant) + i) % NUM_REQ);
         if (req[idx]) begin
            pick = idx;
            found = 1'b1;
         end
      end
   end
   always_comb begin
      state_next = state;
      grant_next = grant_id;
      last_grant_next = last_grant;
      value_next = isr_value;
      result_next = resp_result;
      timeout_next = resp_timeout;
      watchdog_next = watchdog;
      case (state)
         IDLE: if (found) begin
            state_next = LOAD;
            grant_next = pick;
            value_next = req_value[{pick, 6'd0} +: 64];
         end
         LOAD: state_next = SETTLE;
         SETTLE: begin
            watchdog_next = '0;
            state_next = WAIT;
         end
         WAIT: if (isr_done) begin
            result_next = isr_result;
            timeout_next = 1'b0;
            state_next = RESP;
         end else if (watchdog == CW'(TIMEOUT - 1)) begin
            result_next = '0;
            timeout_next = 1'b1;
            state_next = RESP;
         end else begin
            watchdog_next = watchdog + 1'b1;
         end
         RESP: begin
            last_grant_next = grant_id;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         grant_id <= '0;
         last_grant <= IW'(NUM_REQ - 1);
         isr_value <= '0;
         resp_result <= '0;
         resp_timeout <= 1'b0;
         watchdog <= '0;
      end else begin
         state <= state_next;
         grant_id <= grant_next;
         last_grant <= last_grant_next;
         isr_value <= value_next;
         resp_result <= result_next;
         resp_timeout <= timeout_next;
         watchdog <= watchdog_next;
      end
   end
   assign ack = (state == RESP) ? NUM_REQ'(1) << grant_id : '0;
   assign busy = state != IDLE;
   assign isr_reset = reset | (state == LOAD);
endmodule

// File: doc/isr_arbiter.md
# isr_arbiter

Round-robin controller that shares one integer-square-root unit among NUM_REQ requesters. It arbitrates pending requests and loads the winner's 64-bit operand into the unit by pulsing the unit's reset. It waits for the unit's done, with a watchdog, and returns the 32-bit root to the winning requester with a one-cycle acknowledge. It sits between the request sources and the single square-root datapath, and it owns that datapath's reset/start line.

## Interface
- NUM_REQ, 4: number of requesters (2..16)
- TIMEOUT, 1024: maximum cycles spent waiting for unit done before aborting (≥2)
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- req  in  NUM_REQ  per-requester request level
- req_value  in  64*NUM_REQ  operands; requester i at bits [64*i+63:64*i]
- ack  out  NUM_REQ  one-cycle completion pulse, one-hot
- resp_result  out  32  root for the acked requester; valid only while ack≠0
- resp_timeout  out  1  asserted with ack when the watchdog fired
- busy  out  1  high in any state other than IDLE
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester
- isr_reset  out  1  drives the square-root unit's reset (load/start)
- isr_value  out  64  operand to the square-root unit
- isr_result  in  32  unit result
- isr_done  in  1  unit completion flag

## Operation
- Registered state machine: IDLE → LOAD → SETTLE → WAIT → RESP → IDLE.
- **IDLE**
  - If any req bit is high, select the first requester at or after (last_grant+1) mod NUM_REQ.
  - Latch its index into grant_id and its operand into isr_value, then go to LOAD.
  - If no req bit is high, stay in IDLE.
- **LOAD**: isr_reset=1 for exactly one cycle; isr_value holds the latched operand. Go to SETTLE.
- **SETTLE**: one cycle. isr_done is ignored, because the unit's done is invalid immediately after reset. Clear the watchdog counter. Go to WAIT.
- **WAIT**
  - When isr_done=1, register isr_result into resp_result, set resp_timeout=0, and go to RESP.
  - Otherwise increment the watchdog counter.
  - If the counter equals TIMEOUT-1 and isr_done=0, set resp_result=0 and resp_timeout=1, then go to RESP.
  - If isr_done=1 and the timeout condition occur in the same cycle, isr_done wins.
- **RESP**: ack[grant_id]=1 for one cycle; last_grant←grant_id. Go to IDLE.
- isr_value stays constant from LOAD through RESP.
- isr_reset = reset OR (state==LOAD), so a controller reset also holds the unit in reset.
- Requester protocol:
  - Hold req high and req_value stable until ack is seen.
  - Drop req at the same edge that samples ack high.
  - A req withdrawn while being served does not cancel the operation; ack still pulses.
  - req_value of non-granted requesters may change freely.
- Fairness: after serving requester k, k has lowest priority. Every continuously asserted request is served within NUM_REQ grants.
- Widths: result is the floor square root, 32 bits; value 2^64-1 yields 0xFFFFFFFF. The arbiter passes data through and performs no arithmetic on it. The watchdog counter is $clog2(TIMEOUT) bits and never wraps.

## Timing
- Reset values:
  - state=IDLE, ack=0, resp_result=0, resp_timeout=0, busy=0, grant_id=0
  - isr_value=0, watchdog=0
  - last_grant=NUM_REQ-1, so requester 0 has first priority
  - isr_reset=1 while reset is high
- Reset mid-operation (any state): all outputs take their reset values immediately (asynchronous). The in-flight request is dropped without ack. The requester keeps req high and is re-arbitrated after reset release.
- Latency from the IDLE cycle in which req is sampled:
  - LOAD at +1, SETTLE at +2, first WAIT cycle at +3.
  - If isr_done is first seen in WAIT cycle w (w=1 for the first WAIT cycle), ack is high in cycle +3+w.
- Timeout: ack with resp_timeout=1 at +3+TIMEOUT.
- Throughput: back-to-back grants have exactly one IDLE cycle between RESP and the next LOAD. Minimum request-to-request period is 4+w cycles.
- busy falls in the IDLE cycle following RESP.

## Test plan
- Single request 0 with value 144 → one isr_reset pulse carrying 144; ack=4'b0001; resp_result=12; resp_timeout=0; grant_id=0.
- Boundary operands 0, 1, and 2^64-1 on requester 2 → results 0, 1, 0xFFFFFFFF, each with ack=4'b0100.
- All four requesters held high from reset, values 16/25/36/49 → ack order 0,1,2,3 with results 4,5,6,7. Requester 0 re-asserting after its ack is served only after requester 3.
- Stub holding isr_done=0, TIMEOUT=16 → ack at request-cycle+19 with resp_timeout=1, resp_result=0. The next request then completes normally.
- Stub asserting isr_done during SETTLE and during the final timeout cycle → done ignored in SETTLE; done taken (resp_timeout=0) in the final timeout cycle.
- Reset asserted during WAIT for requester 1 → ack stays 0, busy=0, isr_reset=1. After release, requester 1 is re-granted and receives the correct root.
